bcd_conv_scheduler: RTL and testbench
=====================================

BCD_CONV_SCHEDULER -- requirements
Module: bcd_conv_scheduler

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1: the number of WAIT cycles allowed for the shared combinational binary-to-BCD converter to settle (legal range 1..7).
REQ-002 The block SHALL have port CLK, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port REQ, input, 3 bits: per-channel conversion request (level), ch0 = seconds, ch1 = minutes, ch2 = hours.
REQ-005 The block SHALL have ports DIN0, DIN1 and DIN2, input, 8 bits each: binary value per channel (0..255).
REQ-006 The block SHALL have port CONV_A, output, 8 bits: operand driven to the shared converter.
REQ-007 The block SHALL have ports CONV_ONES (input, 4 bits), CONV_TENS (input, 4 bits) and CONV_HUNDREDS (input, 2 bits): result returned by the converter.
REQ-008 The block SHALL have port GNT, output, 3 bits: one-hot grant, high while that channel owns the converter.
REQ-009 The block SHALL have port DONE, output, 3 bits: one-cycle pulse marking a channel's result as updated.
REQ-010 The block SHALL have ports BCD0, BCD1 and BCD2, output, 10 bits each: registered result {HUNDREDS[1:0], TENS[3:0], ONES[3:0]}.
REQ-011 The block SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have three states, IDLE, WAIT and CAPT, encoded in 2 bits.
REQ-013 IDLE with REQ != 0: at the next edge the block SHALL select a winner round-robin, register DIN[winner] into CONV_A, set GNT one-hot, and go to WAIT.
REQ-014 IDLE with REQ == 0: the block SHALL hold all outputs, with GNT = 0 and CONV_A unchanged.
REQ-015 Round-robin: the search SHALL start at the channel after the last served channel, wrapping 2 -> 0; after reset the search SHALL start at ch0.
REQ-016 WAIT SHALL last exactly SETTLE cycles, counted by a 3-bit down-counter, and then go to CAPT; CONV_A and GNT SHALL stay stable throughout WAIT.
REQ-017 On entry to CAPT, BCDn of the granted channel SHALL be loaded from {CONV_HUNDREDS, CONV_TENS, CONV_ONES} sampled at the last WAIT edge; the other BCD registers SHALL be unchanged.
REQ-018 CAPT SHALL last one cycle: DONE[winner] = 1 and GNT = 0; the next state SHALL be IDLE, and the round-robin pointer SHALL be updated to the winner.
REQ-019 Latency: with REQ first sampled high in IDLE at cycle 0, DONE SHALL be high in cycle SETTLE+1; throughput SHALL be one conversion per SETTLE+2 cycles.
REQ-020 DINn SHALL be sampled only at the IDLE->WAIT edge; later changes SHALL NOT affect the result in flight.
REQ-021 REQ deasserted mid-conversion: the conversion SHALL complete and BCDn and DONE SHALL still be updated.
REQ-022 A requester holding REQ through DONE SHALL be re-arbitrated in the following IDLE cycle, subject to the round-robin rule.
REQ-023 At most one DONE bit and at most one GNT bit SHALL be high in any cycle.
REQ-024 The block SHALL perform no arithmetic on the BCD values; it SHALL pass the converter result through bit-exact.

Reset
REQ-025 While RST_N = 0, asynchronously: state = IDLE, CONV_A = 0, GNT = 0, DONE = 0, BCD0/1/2 = 0, BUSY = 0, counter = 0, round-robin pointer = ch2 (so that ch0 is served first).
REQ-026 Reset asserted mid-WAIT or mid-CAPT SHALL abort the conversion: no DONE pulse and no BCD update.
REQ-027 After RST_N deassertion, the first arbitration SHALL occur at the first rising edge with RST_N = 1.

Structure
REQ-028 Package bcd_sched_pkg SHALL hold the state typedef, NCH = 3, BCD_W = 10, and the SETTLE counter width.
REQ-029 A sub-module rr_arb3 SHALL be used: a combinational 3-way round-robin priority selector (inputs REQ and last pointer, output one-hot winner).
REQ-030 The binary-to-BCD converter SHALL be instantiated outside this block and connected through the CONV_* ports.

Verification
REQ-031 The bench SHALL cover: after reset, REQ=001, DIN0=59 -> DONE=001 in cycle 2 (SETTLE=1), BCD0=00_0101_1001.
REQ-032 The bench SHALL cover: REQ=111 held, DIN0=7, DIN1=45, DIN2=255 -> DONE order 001, 010, 100 at 3-cycle spacing; BCD2=10_0101_0101.
REQ-033 The bench SHALL cover: ch1 served last, then REQ=011 -> ch0 is granted before ch1 (pointer wrap).
REQ-034 The bench SHALL cover: DIN0 changes 59 -> 12 during WAIT -> BCD0=00_0101_1001.
REQ-035 The bench SHALL cover: REQ dropped during WAIT -> DONE still pulses and BCD is updated.
REQ-036 The bench SHALL cover: RST_N low during WAIT -> all outputs 0 immediately, no DONE; ch0 is served first after release.

Source files
------------

// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
package bcd_sched_pkg;

    // Number of requesting channels (seconds, minutes, hours).
    localparam int NCH   = 3;
    // Width of one packed BCD result {hundreds[1:0], tens[3:0], ones[3:0]}.
    localparam int BCD_W = 10;
    // Width of the WAIT down-counter; holds settle counts 1..7.
    localparam int CNT_W = 3;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2
    } state_t;

    // Convert a one-hot channel vector into a channel index.
    function automatic logic [1:0] oh2idx(input logic [NCH-1:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/bcd_conv_scheduler_if.sv
// Request/data/result bundle between requesters, converter and scheduler.
interface bcd_conv_scheduler_if;

    logic [2:0] REQ;
    logic [7:0] DIN0;
    logic [7:0] DIN1;
    logic [7:0] DIN2;
    logic [7:0] CONV_A;
    logic [3:0] CONV_ONES;
    logic [3:0] CONV_TENS;
    logic [1:0] CONV_HUNDREDS;
    logic [2:0] GNT;
    logic [2:0] DONE;
    logic [9:0] BCD0;
    logic [9:0] BCD1;
    logic [9:0] BCD2;
    logic       BUSY;

    // Requester / converter side.
    modport master (
        output REQ, DIN0, DIN1, DIN2, CONV_ONES, CONV_TENS, CONV_HUNDREDS,
        input  CONV_A, GNT, DONE, BCD0, BCD1, BCD2, BUSY
    );

    // Scheduler side.
    modport slave (
        input  REQ, DIN0, DIN1, DIN2, CONV_ONES, CONV_TENS, CONV_HUNDREDS,
        output CONV_A, GNT, DONE, BCD0, BCD1, BCD2, BUSY
    );

endinterface

// File: rtl/bcd_conv_scheduler_rr_arb3.sv
// Combinational 3-way round-robin selector: searches from the channel
// after last_i, wrapping 2 -> 0, and returns a one-hot winner.
module rr_arb3 (
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [2:0] win_o
);

    // Priority search in the rotated order implied by the last winner.
    always_comb begin
        win_o = 3'b000;
        case (last_i)
            2'd0: begin
                if      (req_i[1]) win_o = 3'b010;
                else if (req_i[2]) win_o = 3'b100;
                else if (req_i[0]) win_o = 3'b001;
                else               win_o = 3'b000;
            end
            2'd1: begin
                if      (req_i[2]) win_o = 3'b100;
                else if (req_i[0]) win_o = 3'b001;
                else if (req_i[1]) win_o = 3'b010;
                else               win_o = 3'b000;
            end
            default: begin
                if      (req_i[0]) win_o = 3'b001;
                else if (req_i[1]) win_o = 3'b010;
                else if (req_i[2]) win_o = 3'b100;
                else               win_o = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Time-shares one external binary-to-BCD converter among three channels.
// A winner's operand is latched into CONV_A, held for SETTLE cycles, and
// the converter result is captured into that channel's BCD register.
module bcd_conv_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    bcd_conv_scheduler_if.slave   bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         sel_q, sel_d;
    logic [7:0]         conv_a_q, conv_a_d;
    logic [NCH-1:0]     gnt_q, gnt_d;
    logic [NCH-1:0]     done_q, done_d;
    logic [BCD_W-1:0]   bcd0_q, bcd0_d;
    logic [BCD_W-1:0]   bcd1_q, bcd1_d;
    logic [BCD_W-1:0]   bcd2_q, bcd2_d;
    logic               busy_q, busy_d;

    logic [NCH-1:0]     win_oh_s;
    logic [1:0]         win_idx_s;
    logic [7:0]         din_win_s;
    logic [BCD_W-1:0]   conv_res_s;
    logic               settle_end_s;

    rr_arb3 u_arb (
        .req_i  (bus.REQ),
        .last_i (ptr_q),
        .win_o  (win_oh_s)
    );

    assign win_idx_s    = oh2idx(win_oh_s);
    assign conv_res_s   = {bus.CONV_HUNDREDS, bus.CONV_TENS, bus.CONV_ONES};
    assign settle_end_s = (cnt_q <= CNT_W'(1));

    // Operand mux for the arbitration winner.
    always_comb begin
        case (win_idx_s)
            2'd0:    din_win_s = bus.DIN0;
            2'd1:    din_win_s = bus.DIN1;
            2'd2:    din_win_s = bus.DIN2;
            default: din_win_s = 8'd0;
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ != 3'b000) state_d = ST_WAIT;
                else                   state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (settle_end_s) state_d = ST_CAPT;
                else              state_d = ST_WAIT;
            end
            ST_CAPT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; every register holds unless changed here.
    always_comb begin
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        conv_a_d = conv_a_q;
        gnt_d    = gnt_q;
        done_d   = 3'b000;
        bcd0_d   = bcd0_q;
        bcd1_d   = bcd1_q;
        bcd2_d   = bcd2_q;
        busy_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ != 3'b000) begin
                    conv_a_d = din_win_s;
                    gnt_d    = win_oh_s;
                    sel_d    = win_idx_s;
                    cnt_d    = CNT_W'(SETTLE);
                end else begin
                    gnt_d    = 3'b000;
                end
            end
            ST_WAIT: begin
                if (settle_end_s) begin
                    cnt_d  = CNT_W'(0);
                    gnt_d  = 3'b000;
                    done_d = gnt_q;
                    case (sel_q)
                        2'd0:    bcd0_d = conv_res_s;
                        2'd1:    bcd1_d = conv_res_s;
                        2'd2:    bcd2_d = conv_res_s;
                        default: bcd0_d = bcd0_q;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CAPT: begin
                gnt_d = 3'b000;
                ptr_d = sel_q;
            end
            default: begin
                gnt_d = 3'b000;
                cnt_d = CNT_W'(0);
            end
        endcase
    end

    // Datapath and output registers; reset pointer to ch2 so ch0 wins first.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= CNT_W'(0);
            ptr_q    <= 2'd2;
            sel_q    <= 2'd0;
            conv_a_q <= 8'd0;
            gnt_q    <= 3'b000;
            done_q   <= 3'b000;
            bcd0_q   <= 10'd0;
            bcd1_q   <= 10'd0;
            bcd2_q   <= 10'd0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            conv_a_q <= conv_a_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            bcd0_q   <= bcd0_d;
            bcd1_q   <= bcd1_d;
            bcd2_q   <= bcd2_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.CONV_A = conv_a_q;
    assign bus.GNT    = gnt_q;
    assign bus.DONE   = done_q;
    assign bus.BCD0   = bcd0_q;
    assign bus.BCD1   = bcd1_q;
    assign bus.BCD2   = bcd2_q;
    assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler (SETTLE = 1) with a behavioural
// binary-to-BCD converter attached to the CONV_* ports.
module tb_bcd_conv_scheduler;

    logic CLK;
    logic RST_N;
    int   n_vec;
    int   n_err;

    bcd_conv_scheduler_if bus ();

    bcd_conv_scheduler #(.SETTLE(1)) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // External converter model.
    always_comb begin
        bus.CONV_ONES     = 4'(bus.CONV_A % 8'd10);
        bus.CONV_TENS     = 4'((bus.CONV_A / 8'd10) % 8'd10);
        bus.CONV_HUNDREDS = 2'(bus.CONV_A / 8'd100);
    end

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Global time limit.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_gnt"},  32'(bus.GNT),    32'h0);
        check_val({tag, "_done"}, 32'(bus.DONE),   32'h0);
        check_val({tag, "_busy"}, 32'(bus.BUSY),   32'h0);
        check_val({tag, "_conva"},32'(bus.CONV_A), 32'h0);
        check_val({tag, "_bcd0"}, 32'(bus.BCD0),   32'h0);
        check_val({tag, "_bcd1"}, 32'(bus.BCD1),   32'h0);
        check_val({tag, "_bcd2"}, 32'(bus.BCD2),   32'h0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        check_all_zero("rst");
        step();
        step();
        RST_N = 1'b1;
    endtask

    logic [2:0] exp_gnt  [9];
    logic [2:0] exp_done [9];

    initial begin
        n_vec = 0;
        n_err = 0;
        RST_N = 1'b0;
        bus.REQ  = 3'b000;
        bus.DIN0 = 8'd0;
        bus.DIN1 = 8'd0;
        bus.DIN2 = 8'd0;
        step();
        do_reset();

        // Single request after reset: DONE two cycles later, BCD0 = 059.
        bus.REQ  = 3'b001;
        bus.DIN0 = 8'd59;
        step();
        check_val("t1_gnt",   32'(bus.GNT),    32'h1);
        check_val("t1_conva", 32'(bus.CONV_A), 32'd59);
        check_val("t1_busy",  32'(bus.BUSY),   32'h1);
        check_val("t1_done0", 32'(bus.DONE),   32'h0);
        bus.REQ = 3'b000;
        step();
        check_val("t1_done",  32'(bus.DONE),   32'h1);
        check_val("t1_gntc",  32'(bus.GNT),    32'h0);
        check_val("t1_bcd0",  32'(bus.BCD0),   32'h059);
        step();
        check_val("t1_idle_done", 32'(bus.DONE), 32'h0);
        check_val("t1_idle_busy", 32'(bus.BUSY), 32'h0);

        // All three held from reset: served 0,1,2 at 3-cycle spacing.
        do_reset();
        exp_gnt  = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
        exp_done = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000};
        bus.REQ  = 3'b111;
        bus.DIN0 = 8'd7;
        bus.DIN1 = 8'd45;
        bus.DIN2 = 8'd255;
        for (int k = 0; k < 9; k++) begin
            step();
            check_val($sformatf("t2_gnt%0d", k + 1),  32'(bus.GNT),  32'(exp_gnt[k]));
            check_val($sformatf("t2_done%0d", k + 1), 32'(bus.DONE), 32'(exp_done[k]));
            if (k == 7) bus.REQ = 3'b000;
        end
        check_val("t2_bcd0", 32'(bus.BCD0), 32'h007);
        check_val("t2_bcd1", 32'(bus.BCD1), 32'h045);
        check_val("t2_bcd2", 32'(bus.BCD2), 32'h255);

        // Serve ch1 alone, then REQ=011: ch0 must win before ch1.
        bus.REQ = 3'b010;
        step();
        check_val("t3_gnt_ch1", 32'(bus.GNT), 32'h2);
        step();
        check_val("t3_done_ch1", 32'(bus.DONE), 32'h2);
        bus.REQ = 3'b011;
        step();
        step();
        check_val("t3_wrap_gnt", 32'(bus.GNT), 32'h1);
        step();
        check_val("t3_wrap_done", 32'(bus.DONE), 32'h1);
        step();
        step();
        check_val("t3_next_gnt", 32'(bus.GNT), 32'h2);
        bus.REQ = 3'b000;
        step();
        check_val("t3_next_done", 32'(bus.DONE), 32'h2);
        step();

        // DIN0 changes during WAIT: in-flight result keeps the old operand.
        bus.REQ  = 3'b001;
        bus.DIN0 = 8'd59;
        step();
        check_val("t4_gnt", 32'(bus.GNT), 32'h1);
        bus.DIN0 = 8'd12;
        bus.REQ  = 3'b000;
        #1;
        check_val("t4_conva", 32'(bus.CONV_A), 32'd59);
        step();
        check_val("t4_done", 32'(bus.DONE), 32'h1);
        check_val("t4_bcd0", 32'(bus.BCD0), 32'h059);
        step();

        // REQ dropped during WAIT: conversion still completes.
        bus.REQ  = 3'b100;
        bus.DIN2 = 8'd99;
        step();
        check_val("t5_gnt", 32'(bus.GNT), 32'h4);
        bus.REQ = 3'b000;
        step();
        check_val("t5_done", 32'(bus.DONE), 32'h4);
        check_val("t5_bcd2", 32'(bus.BCD2), 32'h099);
        step();
        check_val("t5_idle_busy", 32'(bus.BUSY), 32'h0);

        // Reset during WAIT aborts; ch0 served first after release.
        bus.REQ  = 3'b010;
        bus.DIN1 = 8'd80;
        step();
        check_val("t6_gnt", 32'(bus.GNT), 32'h2);
        RST_N = 1'b0;
        #1;
        check_all_zero("t6_async");
        step();
        check_val("t6_nodone_a", 32'(bus.DONE), 32'h0);
        step();
        check_val("t6_nodone_b", 32'(bus.DONE), 32'h0);
        check_val("t6_bcd1", 32'(bus.BCD1), 32'h0);
        RST_N   = 1'b1;
        bus.REQ = 3'b011;
        step();
        check_val("t6_first_gnt", 32'(bus.GNT), 32'h1);
        bus.REQ = 3'b000;
        step();
        check_val("t6_first_done", 32'(bus.DONE), 32'h1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
